// File: rtl/reg_writeback_unit.sv
// Register-file write-port merger: ALU results and FIFO-buffered load results share one
// registered write port; a pending-load scoreboard flags RAW hazards. Optional WB_BYPASS_EN.
module reg_writeback_unit #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [ADDR_W-1:0] ld_rd_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_issue_valid_i,
  input  logic [ADDR_W-1:0] ld_issue_rd_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              reg_write_enable_o,
  output logic [ADDR_W-1:0] write_address_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic              fwd1_valid_o,
  output logic              fwd2_valid_o,
  output logic [DATA_W-1:0] fwd1_data_o,
  output logic [DATA_W-1:0] fwd2_data_o
);

  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic              we_q, we_d;
  logic              wb_load_q, wb_load_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NumRegs-1:0] busy_q, busy_d;

  logic full, empty, push, pop, alu_sel;
  logic              sel_valid, sel_load;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  assign ld_ready_o  = !full;
  assign alu_ready_o = !full;
  assign push        = ld_valid_i && !full;
  // A full FIFO takes priority so loads cannot starve behind continuous ALU traffic.
  assign alu_sel     = !full && alu_valid_i;
  assign pop         = full || (!alu_valid_i && !empty);

  always_comb begin
    sel_valid = alu_sel || pop;
    sel_load  = pop;
    sel_rd    = pop ? rd_mem_q[rd_ptr_q]   : alu_rd_i;
    sel_data  = pop ? data_mem_q[rd_ptr_q] : alu_data_i;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Address/data hold when no real write is produced (including rd=0 slots).
  always_comb begin
    we_d      = sel_valid && (sel_rd != '0);
    wb_load_d = sel_load;
    waddr_d   = we_d ? sel_rd   : waddr_q;
    wdata_d   = we_d ? sel_data : wdata_q;
  end

  // Clear on a load-sourced write first so a same-cycle issue to that rd wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q && wb_load_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (ld_issue_valid_i && (ld_issue_rd_i != '0)) begin
      busy_d[ld_issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= ld_rd_i;
      data_mem_q[wr_ptr_q] <= ld_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      wb_load_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      wb_load_q <= wb_load_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
    end
  end

  assign reg_write_enable_o = we_q;
  assign write_address_o    = waddr_q;
  assign write_data_o       = wdata_q;

`ifdef WB_BYPASS_EN
  assign fwd1_valid_o = we_q && (waddr_q == rs1_addr_i) && (rs1_addr_i != '0);
  assign fwd2_valid_o = we_q && (waddr_q == rs2_addr_i) && (rs2_addr_i != '0);
  assign fwd1_data_o  = wdata_q;
  assign fwd2_data_o  = wdata_q;
  assign rs1_busy_o   = busy_q[rs1_addr_i] && !fwd1_valid_o;
  assign rs2_busy_o   = busy_q[rs2_addr_i] && !fwd2_valid_o;
`else
  assign fwd1_valid_o = 1'b0;
  assign fwd2_valid_o = 1'b0;
  assign fwd1_data_o  = '0;
  assign fwd2_data_o  = '0;
  assign rs1_busy_o   = busy_q[rs1_addr_i];
  assign rs2_busy_o   = busy_q[rs2_addr_i];
`endif

endmodule
